// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: func3 encodings,
// FSM states and operand-sign helpers.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a shift-add multiply step or a restoring
// divide step. Purely combinational; the sequencer owns the registers.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN:0]       rem_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [2*XLEN-1:0]   acc_o,
    output logic [XLEN:0]       rem_o
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic            borrow;

    always_comb begin
        // Multiply: multiplier sits in the low half and is consumed LSB first.
        mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
        // Divide: dividend sits in the low half and is consumed MSB first.
        shifted = {rem_i, acc_i[XLEN-1]};
        diff    = shifted - {2'b00, b_i};
        borrow  = diff[XLEN+1];
        if (is_div) begin
            acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], ~borrow};
            rem_o = borrow ? shifted[XLEN:0] : diff[XLEN:0];
        end else begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
            rem_o = rem_i;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: accepts one op, iterates XLEN steps on
// magnitudes, fixes up signs, and holds the tagged result until consumed.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy
);

    localparam logic [5:0]      LAST_STEP = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [TAG_W-1:0]  rd_q, rd_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              pre_sa, pre_sb;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] step_acc, prod_fix;
    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div(op_q)),
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .b_i    (b_q),
        .acc_o  (step_acc),
        .rem_o  (step_rem)
    );

    assign pre_sa   = is_signed_a(op_q) & a_q[XLEN-1];
    assign pre_sb   = is_signed_b(op_q) & b_q[XLEN-1];
    assign abs_a    = pre_sa ? -a_q : a_q;
    assign abs_b    = pre_sb ? -b_q : b_q;
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix  = ((op_q == MD_DIV) && (sign_a_q ^ sign_b_q)) ? -acc_q[XLEN-1:0]
                                                                   : acc_q[XLEN-1:0];
    assign rem_fix  = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    rd_d    = in_rd;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_a_d = pre_sa;
                sign_b_d = pre_sb;
                acc_d    = {{XLEN{1'b0}}, abs_a};
                rem_d    = '0;
                b_d      = abs_b;
                cnt_d    = '0;
                state_d  = S_CALC;
                // Divide-by-zero and signed overflow have fixed RISC-V results.
                if (is_div(op_q) && (b_q == '0)) begin
                    res_d   = ((op_q == MD_DIV) || (op_q == MD_DIVU)) ? '1 : a_q;
                    state_d = S_DONE;
                end else if (((op_q == MD_DIV) || (op_q == MD_REM)) &&
                             (a_q == INT_MIN) && (b_q == '1)) begin
                    res_d   = (op_q == MD_DIV) ? INT_MIN : '0;
                    state_d = S_DONE;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                case (op_q)
                    MD_MUL:                res_d = prod_fix[XLEN-1:0];
                    MD_MULH, MD_MULHSU,
                    MD_MULHU:              res_d = prod_fix[2*XLEN-1:XLEN];
                    MD_DIV, MD_DIVU:       res_d = quo_fix;
                    default:               res_d = rem_fix;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a driver pushes expected tag/result and
// arrival cycle per op; an independent monitor checks every result handshake.
module tb_muldiv_sequencer;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int W     = 32 + TAG_W + XLEN;
    localparam int LAT_N = 34;  // edges from acceptance edge to first out_valid cycle
    localparam int LAT_F = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_rd = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_rd;
    logic             busy;

    muldiv_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] head;
    bit seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                if (!seen) chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                seen = 1'b1;
            end else begin
                head = exp_q[0];
                if (!seen) begin
                    chk("latency", 64'(cyc), {32'd0, head[W-1 -: 32]});
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk("result", {32'd0, out_result}, {32'd0, head[XLEN-1:0]});
                    chk("rd", {59'd0, out_rd}, {59'd0, head[XLEN +: TAG_W]});
                    void'(exp_q.pop_front());
                end
            end
            if (out_ready) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    // driver: called just after a rising edge; returns #1 after the acceptance edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         input bit expect_it);
        bit acc = 1'b0;
        in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=in_ready_low expected=accept op=%0d", op);
        end else if (expect_it) begin
            exp_q.push_back({32'(cyc + lat), rd, res});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // multiply, incl. sign-mix corner cases
        issue(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT_N, 1);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, LAT_N, 1);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, LAT_N, 1);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, LAT_N, 1);
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001, LAT_N, 1);
        issue(3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, LAT_N, 1);
        // divide / remainder
        issue(3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, LAT_N, 1);
        issue(3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, LAT_N, 1);
        issue(3'd5, 32'd100,      32'd7,        5'd10, 32'd14,       LAT_N, 1);
        issue(3'd7, 32'd100,      32'd7,        5'd11, 32'd2,        LAT_N, 1);
        issue(3'd4, 32'd20,       32'hFFFFFFFD, 5'd12, 32'hFFFFFFFA, LAT_N, 1);
        issue(3'd6, 32'd20,       32'hFFFFFFFD, 5'd13, 32'd2,        LAT_N, 1);
        // fast paths
        issue(3'd5, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, LAT_F, 1);
        issue(3'd7, 32'd5,        32'd0,        5'd15, 32'd5,        LAT_F, 1);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, LAT_F, 1);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        LAT_F, 1);
        issue(3'd4, 32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, LAT_F, 1);
        issue(3'd6, 32'hFFFFFFFB, 32'd0,        5'd20, 32'hFFFFFFFB, LAT_F, 1);
        drain();

        // consumer back-pressure in DONE
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, LAT_N, 1);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_out_result", {32'd0, out_result}, 64'd14);
            chk("stall_out_rd", {59'd0, out_rd}, 64'd9);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("after_consume_in_ready", {63'd0, in_ready}, 64'd1);
        chk("after_consume_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // flush mid-calculation: nothing may be emitted
        issue(3'd0, 32'd9, 32'd9, 5'd21, 32'd81, LAT_N, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // flush wins over a same-cycle in_valid
        in_op = 3'd0; in_a = 32'd3; in_b = 32'd3; in_rd = 5'd22;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_vs_valid_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // synchronous reset mid-operation
        issue(3'd0, 32'd6, 32'd7, 5'd17, 32'd42, LAT_N, 0);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_result", {32'd0, out_result}, 64'd0);
        chk("midrst_out_rd", {59'd0, out_rd}, 64'd0);
        @(posedge clk);
        #1;

        // recovery after reset
        issue(3'd0, 32'd3, 32'd4, 5'd23, 32'd12, LAT_N, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
